// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects and sequencer states.
package pipe_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam int WAIT_W = 16;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decoder-side hazard inputs and pipeline-control outputs of the hazard controller.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_rs1;
  logic [4:0]       ex_rs2;
  logic [4:0]       ex_rd;
  logic             ex_regwrite;
  logic             ex_memread;
  logic [4:0]       mem_rd;
  logic             mem_regwrite;
  logic [4:0]       wb_rd;
  logic             wb_regwrite;
  logic             ex_redirect;
  logic             dmem_req;
  logic             dmem_ready;
  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             mem_err;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_rs1, ex_rs2, ex_rd, ex_regwrite, ex_memread,
    output mem_rd, mem_regwrite, wb_rd, wb_regwrite,
    output ex_redirect, dmem_req, dmem_ready,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    input  ifid_flush, idex_flush, fwd_a, fwd_b,
    input  stall_cnt, flush_cnt, mem_err
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_rs1, ex_rs2, ex_rd, ex_regwrite, ex_memread,
    input  mem_rd, mem_regwrite, wb_rd, wb_regwrite,
    input  ex_redirect, dmem_req, dmem_ready,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    output ifid_flush, idex_flush, fwd_a, fwd_b,
    output stall_cnt, flush_cnt, mem_err
  );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd.sv
// EX operand forwarding select for one source register; purely combinational.
module fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] ex_rs,
  input  logic [4:0] mem_rd,
  input  logic       mem_regwrite,
  input  logic [4:0] wb_rd,
  input  logic       wb_regwrite,
  output logic [1:0] fwd
);

  // MEM is younger than WB, so its result wins when both match.
  always_comb begin
    fwd = FWD_RF;
    if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == ex_rs)) begin
      fwd = FWD_MEM;
    end else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == ex_rs)) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline sequencer: stalls, flushes, forwarding and memory-wait freeze.
// Enables/flushes/forwarding act in the same cycle; counters and mem_err one cycle later.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input logic               clk,
  input logic               rstn,
  pipe_hazard_ctrl_if.slave bus
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
  logic              mem_err;
  logic              load_use;
  logic              mem_hold;
  logic              take_redirect;
  logic              pc_en;
  logic              ifid_en;
  logic              idex_en;
  logic              exmem_en;
  logic              memwb_en;
  logic              ifid_flush;
  logic              idex_flush;
  logic              unused_ex_regwrite;

  // EX writeback intent only matters downstream via forwarding from MEM/WB.
  assign unused_ex_regwrite = bus.ex_regwrite;

  always_comb begin
    load_use = bus.ex_memread && (bus.ex_rd != 5'd0) &&
               ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));
    mem_hold = !bus.dmem_ready &&
               (((state == RUN) && bus.dmem_req) || (state == MEM_WAIT));
  end

  always_comb begin
    pc_en         = 1'b1;
    ifid_en       = 1'b1;
    idex_en       = 1'b1;
    exmem_en      = 1'b1;
    memwb_en      = 1'b1;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    take_redirect = 1'b0;
    if (state == BOOT) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (mem_hold) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
    end else if (bus.ex_redirect) begin
      // The ID instruction is on the wrong path, so redirect overrides load-use.
      ifid_flush    = 1'b1;
      idex_flush    = 1'b1;
      take_redirect = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= BOOT;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      mem_err   <= 1'b0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (bus.dmem_req && !bus.dmem_ready) begin
            state    <= MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (bus.dmem_ready) begin
            state <= RUN;
          end
          if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
          if (wait_cnt >= WAIT_LAST) begin
            mem_err <= 1'b1;
          end
        end
        default: state <= BOOT;
      endcase
      if ((state != BOOT) && !pc_en) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (take_redirect) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

  fwd_unit u_fwd_a (
    .ex_rs        (bus.ex_rs1),
    .mem_rd       (bus.mem_rd),
    .mem_regwrite (bus.mem_regwrite),
    .wb_rd        (bus.wb_rd),
    .wb_regwrite  (bus.wb_regwrite),
    .fwd          (bus.fwd_a)
  );

  fwd_unit u_fwd_b (
    .ex_rs        (bus.ex_rs2),
    .mem_rd       (bus.mem_rd),
    .mem_regwrite (bus.mem_regwrite),
    .wb_rd        (bus.wb_rd),
    .wb_regwrite  (bus.wb_regwrite),
    .fwd          (bus.fwd_b)
  );

  assign bus.pc_en      = pc_en;
  assign bus.ifid_en    = ifid_en;
  assign bus.idex_en    = idex_en;
  assign bus.exmem_en   = exmem_en;
  assign bus.memwb_en   = memwb_en;
  assign bus.ifid_flush = ifid_flush;
  assign bus.idex_flush = idex_flush;
  assign bus.stall_cnt  = stall_cnt;
  assign bus.flush_cnt  = flush_cnt;
  assign bus.mem_err    = mem_err;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, hand sequences and random run vs. a reference model.
module tb_pipe_hazard_ctrl;

  localparam int CW = 8;
  localparam int TO = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();

  pipe_hazard_ctrl #(.CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct packed {
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       use1;
    logic       use2;
    logic [4:0] ex_rs1;
    logic [4:0] ex_rs2;
    logic [4:0] ex_rd;
    logic       ex_rw;
    logic       ex_mr;
    logic [4:0] mem_rd;
    logic       mem_rw;
    logic [4:0] wb_rd;
    logic       wb_rw;
    logic       redir;
    logic       req;
    logic       rdy;
  } in_t;

  typedef struct {
    in_t         v;
    logic [10:0] e;
    string       nm;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nbad = 0;

  // Reference model: spec-level view of the sequencer.
  bit m_boot = 1'b1;
  bit m_wait = 1'b0;
  int m_wlen = 0;
  int m_stall = 0;
  int m_flush = 0;
  bit m_err = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  function automatic logic [1:0] m_fwd(input logic [4:0] rs, input logic [4:0] mrd, input logic mrw,
                                      input logic [4:0] wrd, input logic wrw);
    if (mrw && mrd != 0 && mrd == rs) return 2'b01;
    if (wrw && wrd != 0 && wrd == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit m_frozen(input in_t v);
    return !v.rdy && (m_wait || v.req);
  endfunction

  function automatic logic [10:0] m_ctl(input in_t v);
    logic [3:0] fw;
    bit lu;
    fw = {m_fwd(v.ex_rs1, v.mem_rd, v.mem_rw, v.wb_rd, v.wb_rw),
          m_fwd(v.ex_rs2, v.mem_rd, v.mem_rw, v.wb_rd, v.wb_rw)};
    lu = v.ex_mr && v.ex_rd != 0 &&
         ((v.use1 && v.id_rs1 == v.ex_rd) || (v.use2 && v.id_rs2 == v.ex_rd));
    if (m_boot)      return {5'b00000, 2'b11, fw};
    if (m_frozen(v)) return {5'b00000, 2'b00, fw};
    if (v.redir)     return {5'b11111, 2'b11, fw};
    if (lu)          return {5'b00111, 2'b01, fw};
    return {5'b11111, 2'b00, fw};
  endfunction

  task automatic model_edge(input in_t v);
    logic [10:0] c;
    c = m_ctl(v);
    if (m_boot) begin
      m_boot = 1'b0;
    end else begin
      if (!c[10]) m_stall = (m_stall + 1) % (1 << CW);
      if (v.redir && !m_frozen(v)) m_flush = (m_flush + 1) % (1 << CW);
      if (m_wait) begin
        m_wlen++;
        if (m_wlen >= TO) m_err = 1'b1;
        if (v.rdy) m_wait = 1'b0;
      end else if (v.req && !v.rdy) begin
        m_wait = 1'b1;
        m_wlen = 0;
      end
    end
  endtask

  task automatic drive(input in_t v);
    bus.id_rs1 = v.id_rs1;       bus.id_rs2 = v.id_rs2;
    bus.id_use_rs1 = v.use1;     bus.id_use_rs2 = v.use2;
    bus.ex_rs1 = v.ex_rs1;       bus.ex_rs2 = v.ex_rs2;
    bus.ex_rd = v.ex_rd;         bus.ex_regwrite = v.ex_rw;
    bus.ex_memread = v.ex_mr;    bus.mem_rd = v.mem_rd;
    bus.mem_regwrite = v.mem_rw; bus.wb_rd = v.wb_rd;
    bus.wb_regwrite = v.wb_rw;   bus.ex_redirect = v.redir;
    bus.dmem_req = v.req;        bus.dmem_ready = v.rdy;
  endtask

  function automatic logic [10:0] dut_ctl();
    return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
            bus.ifid_flush, bus.idex_flush, bus.fwd_a, bus.fwd_b};
  endfunction

  task automatic check_all(input string nm, input in_t v);
    check({nm, "_ctl"}, {21'd0, dut_ctl()}, {21'd0, m_ctl(v)});
    check({nm, "_cnt"}, {15'd0, bus.stall_cnt, bus.flush_cnt, bus.mem_err},
          {15'd0, 8'(m_stall), 8'(m_flush), m_err});
  endtask

  task automatic step(input in_t v, input bit use_e, input logic [10:0] e, input string nm);
    @(negedge clk);
    drive(v);
    #1;
    check_all(nm, v);
    if (use_e) check({nm, "_exp"}, {21'd0, dut_ctl()}, {21'd0, e});
    if (rstn) model_edge(v);
  endtask

  task automatic do_reset(input in_t v);
    @(negedge clk);
    drive(v);
    rstn = 1'b0;
    m_boot = 1'b1; m_wait = 1'b0; m_wlen = 0;
    m_stall = 0;   m_flush = 0;   m_err = 1'b0;
    #1;
    check_all("async_rst", v);
    check("rst_boot_out", {21'd0, dut_ctl()},
          {21'd0, 5'b00000, 2'b11, m_fwd(v.ex_rs1, v.mem_rd, v.mem_rw, v.wb_rd, v.wb_rw),
           m_fwd(v.ex_rs2, v.mem_rd, v.mem_rw, v.wb_rd, v.wb_rw)});
    step(v, 1'b0, '0, "rst_hold");
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic add(input in_t v, input logic [10:0] e, input string nm);
    vec_t t;
    t.v = v; t.e = e; t.nm = nm;
    tbl.push_back(t);
  endtask

  initial begin
    in_t z, v;
    z = '0;
    drive(z);

    // Vector table; all entries apply in RUN with no memory access.
    v = z; add(v, 11'b11111_00_00_00, "idle");
    v = z; v.ex_mr = 1; v.ex_rd = 5; v.id_rs1 = 5; v.use1 = 1;
    add(v, 11'b00111_01_00_00, "loaduse_rs1");
    v = z; add(v, 11'b11111_00_00_00, "after_loaduse");
    v = z; v.ex_mr = 1; v.ex_rd = 5; v.id_rs1 = 5; v.use1 = 0;
    add(v, 11'b11111_00_00_00, "loaduse_unused");
    v = z; v.ex_mr = 1; v.ex_rd = 0; v.id_rs1 = 0; v.use1 = 1;
    add(v, 11'b11111_00_00_00, "loaduse_x0");
    v = z; v.ex_mr = 1; v.ex_rd = 9; v.id_rs2 = 9; v.use2 = 1;
    add(v, 11'b00111_01_00_00, "loaduse_rs2");
    v = z; v.ex_mr = 1; v.ex_rd = 5; v.id_rs1 = 5; v.use1 = 1; v.redir = 1;
    add(v, 11'b11111_11_00_00, "redir_over_lu");
    v = z; v.mem_rd = 7; v.wb_rd = 7; v.ex_rs1 = 7; v.mem_rw = 1; v.wb_rw = 1; v.ex_rs2 = 3;
    add(v, 11'b11111_00_01_00, "fwd_mem_prio");
    v = z; v.mem_rw = 1; v.wb_rw = 1;
    add(v, 11'b11111_00_00_00, "fwd_x0");
    v = z; v.wb_rd = 4; v.wb_rw = 1; v.mem_rd = 4; v.ex_rs1 = 4; v.ex_rs2 = 4;
    add(v, 11'b11111_00_10_10, "fwd_wb");
    v = z; v.mem_rd = 6; v.mem_rw = 1; v.wb_rd = 6; v.wb_rw = 1; v.ex_rs2 = 6; v.ex_rs1 = 2;
    add(v, 11'b11111_00_00_01, "fwd_b_mem");

    // Reset: BOOT outputs while held, forwarding live, one BOOT cycle after release.
    v = z; v.mem_rd = 3; v.mem_rw = 1; v.ex_rs1 = 3;
    step(v, 1'b1, 11'b00000_11_01_00, "in_reset");
    release_rst();
    step(z, 1'b1, 11'b00000_11_00_00, "boot_cycle");

    foreach (tbl[i]) step(tbl[i].v, 1'b1, tbl[i].e, tbl[i].nm);

    // Memory wait of three cycles with a redirect held in EX.
    v = z; v.req = 1; v.redir = 1;
    for (int i = 0; i < 3; i++) step(v, 1'b1, 11'b00000_00_00_00, "mwait_frozen");
    v.rdy = 1;
    step(v, 1'b1, 11'b11111_11_00_00, "mwait_exit_redir");
    step(z, 1'b1, 11'b11111_00_00_00, "mwait_after");

    // Timeout: ready low for six cycles, mem_err must set and stick.
    v = z; v.req = 1;
    for (int i = 0; i < 6; i++) step(v, 1'b1, 11'b00000_00_00_00, "timeout_wait");
    v.rdy = 1;
    step(v, 1'b0, '0, "timeout_exit");
    step(z, 1'b0, '0, "timeout_after");
    check("mem_err_sticky", {31'd0, bus.mem_err}, 32'd1);

    // Reset in the middle of a memory wait with a pending redirect.
    v = z; v.req = 1; v.redir = 1;
    step(v, 1'b0, '0, "pre_rst_wait");
    step(v, 1'b0, '0, "pre_rst_wait");
    do_reset(v);
    release_rst();
    step(z, 1'b1, 11'b00000_11_00_00, "boot_again");
    step(z, 1'b1, 11'b11111_00_00_00, "run_again");

    // Random traffic against the model, with occasional resets.
    for (int n = 0; n < 1500; n++) begin
      v.id_rs1 = 5'($urandom_range(0, 3)); v.id_rs2 = 5'($urandom_range(0, 3));
      v.use1 = 1'($urandom);               v.use2 = 1'($urandom);
      v.ex_rs1 = 5'($urandom_range(0, 3)); v.ex_rs2 = 5'($urandom_range(0, 3));
      v.ex_rd = 5'($urandom_range(0, 3));  v.ex_rw = 1'($urandom);
      v.ex_mr = 1'($urandom);              v.mem_rd = 5'($urandom_range(0, 3));
      v.mem_rw = 1'($urandom);             v.wb_rd = 5'($urandom_range(0, 3));
      v.wb_rw = 1'($urandom);              v.redir = ($urandom_range(0, 5) == 0);
      v.req = ($urandom_range(0, 2) == 0); v.rdy = 1'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        do_reset(v);
        release_rst();
      end else begin
        step(v, 1'b0, '0, "rand");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
